// File: rtl/oh_fifo_wrptr_ctl.sv
// Write-side pointer controller for a dual-clock FIFO: owns the binary write
// pointer, exports a registered Gray copy, and derives occupancy and flags.
module oh_fifo_wrptr_ctl #(
  parameter int unsigned AW    = 4,
  parameter int unsigned AFULL = (1 << AW) - 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW:0]   rd_gray_sync,
  output logic          wr_ack,
  output logic [AW-1:0] wr_addr,
  output logic [AW:0]   wr_gray,
  output logic [AW:0]   wr_count,
  output logic          full,
  output logic          almost_full,
  output logic          overflow
);

  localparam logic [AW:0] LP_DEPTH = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] LP_AFULL = (AW+1)'(AFULL);

  logic [AW:0] r_wr_bin;
  logic [AW:0] r_wr_gray;
  logic [AW:0] r_wr_count;
  logic        r_full;
  logic        r_almost_full;
  logic        r_overflow;

  logic [AW:0] w_wr_bin_next;
  logic [AW:0] w_rd_bin;
  logic [AW:0] w_cnt_next;
  logic        w_ack;

  assign w_ack         = wr_en & ~r_full;
  assign w_wr_bin_next = r_wr_bin + (AW+1)'(w_ack);
  assign w_cnt_next    = w_wr_bin_next - w_rd_bin;

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    w_rd_bin = '0;
    for (int unsigned i = 0; i <= AW; i++) begin
      w_rd_bin[i] = ^(rd_gray_sync >> i);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_bin      <= '0;
      r_wr_gray     <= '0;
      r_wr_count    <= '0;
      r_full        <= 1'b0;
      r_almost_full <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_wr_bin      <= w_wr_bin_next;
      r_wr_gray     <= w_wr_bin_next ^ (w_wr_bin_next >> 1);
      r_wr_count    <= w_cnt_next;
      r_full        <= (w_cnt_next == LP_DEPTH);
      r_almost_full <= (w_cnt_next >= LP_AFULL);
      r_overflow    <= r_overflow | (wr_en & r_full);
    end
  end

  assign wr_ack      = w_ack;
  assign wr_addr     = r_wr_bin[AW-1:0];
  assign wr_gray     = r_wr_gray;
  assign wr_count    = r_wr_count;
  assign full        = r_full;
  assign almost_full = r_almost_full;
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_oh_fifo_wrptr_ctl.sv
// Scoreboard bench for oh_fifo_wrptr_ctl: a push/read counting model queues
// the expected per-cycle response; a monitor compares what the DUT presents.
module tb_oh_fifo_wrptr_ctl;

  localparam int unsigned AW    = 2;
  localparam int unsigned AFULL = 3;
  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned MOD   = 1 << (AW + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_en = 1'b0;
  logic [AW:0]   rd_gray_sync = '0;
  logic          wr_ack;
  logic [AW-1:0] wr_addr;
  logic [AW:0]   wr_gray;
  logic [AW:0]   wr_count;
  logic          full;
  logic          almost_full;
  logic          overflow;

  oh_fifo_wrptr_ctl #(.AW(AW), .AFULL(AFULL)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .rd_gray_sync (rd_gray_sync),
    .wr_ack       (wr_ack),
    .wr_addr      (wr_addr),
    .wr_gray      (wr_gray),
    .wr_count     (wr_count),
    .full         (full),
    .almost_full  (almost_full),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    bit          ack;
    int unsigned addr;
    int unsigned gray;
    int unsigned count;
    bit          full;
    bit          afull;
    bit          ovf;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model: total accepted pushes and total reads as plain counters.
  int unsigned m_wr = 0;
  int unsigned m_rd = 0;
  bit          m_full = 0;
  bit          m_afull = 0;
  bit          m_ovf = 0;

  function automatic int unsigned to_gray(input int unsigned b);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input bit rst, input bit we, input bit adv);
    exp_t e;
    int unsigned occ;
    @(negedge clk);
    if (rst) m_rd = 0;
    else if (adv && m_rd < m_wr) m_rd++;
    reset        = rst;
    wr_en        = we;
    rd_gray_sync = (AW+1)'(to_gray(m_rd % MOD));
    e.rst  = rst;
    e.ack  = we && !m_full;
    e.addr = m_wr % DEPTH;
    if (rst) begin
      m_wr = 0; m_full = 0; m_afull = 0; m_ovf = 0; occ = 0;
    end else begin
      if (e.ack) m_wr++;
      occ     = (m_wr - m_rd) % MOD;
      m_ovf   = m_ovf || (we && m_full);
      m_full  = (occ == DEPTH);
      m_afull = (occ >= AFULL);
    end
    e.gray  = to_gray(m_wr % MOD);
    e.count = occ;
    e.full  = m_full;
    e.afull = m_afull;
    e.ovf   = m_ovf;
    sb.push_back(e);
  endtask

  // Monitor: combinational outputs mid-cycle, registered outputs after the edge.
  initial begin : monitor
    exp_t        e;
    bit          s_ack;
    int unsigned s_addr;
    logic [AW:0] prev_gray = '0;
    forever begin
      @(negedge clk); #2;
      s_ack  = wr_ack;
      s_addr = wr_addr;
      @(posedge clk); #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("wr_ack", s_ack, e.ack);
        if (e.ack) check("wr_addr", s_addr, e.addr);
        check("wr_gray", wr_gray, e.gray);
        check("wr_count", wr_count, e.count);
        check("full", full, e.full);
        check("almost_full", almost_full, e.afull);
        check("overflow", overflow, e.ovf);
        if (!e.rst) check("gray_step_le1", ($countones(wr_gray ^ prev_gray) <= 1), 1);
        prev_gray = wr_gray;
      end
    end
  end

  initial begin : driver
    repeat (2) cycle(1, 0, 0);
    repeat (5) cycle(0, 0, 0);          // reset then idle
    repeat (4) cycle(0, 1, 0);          // fill to full
    repeat (2) cycle(0, 1, 0);          // refused pushes, overflow sticks
    cycle(0, 0, 1);                     // reader advances: full releases
    cycle(0, 1, 0);                     // push accepted at addr 0
    repeat (3) cycle(0, 0, 0);
    cycle(1, 0, 0);
    repeat (16) cycle(0, 1, 1);         // wrap with reader following
    cycle(0, 0, 1);
    cycle(1, 0, 0);
    repeat (2) cycle(0, 1, 0);
    cycle(1, 1, 0);                     // reset wins over push at count 2
    cycle(0, 0, 0);
    for (int n = 0; n < 400; n++) begin
      cycle(($urandom_range(0, 59) == 0), ($urandom_range(0, 2) != 0), ($urandom_range(0, 1) == 1));
    end
    cycle(0, 0, 0);
    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
